// File: rtl/serdes_hdr_err_inject_pkg.sv
// Shared types and constants for the SERDES sync-header error injector.
package serdes_hdr_err_inject_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_INJECT = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] HDR_DATA  = 2'b01;
    localparam logic [1:0] HDR_CTRL  = 2'b10;
    localparam logic [1:0] HDR_BAD00 = 2'b00;
    localparam logic [1:0] HDR_BAD11 = 2'b11;

    // Only the two legal 64b/66b sync headers take part in counting.
    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

// File: rtl/serdes_hdr_err_inject.sv
// One-cycle 66-bit block pass-through that replaces a programmed pattern of
// valid sync headers with an illegal header, for block-lock and BER testing.
module serdes_hdr_err_inject
    import serdes_hdr_err_inject_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned HDR_WIDTH  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    input  logic                  cfg_enable,
    input  logic [CNT_WIDTH-1:0]  cfg_start_count,
    input  logic [CNT_WIDTH-1:0]  cfg_inject_count,
    input  logic [CNT_WIDTH-1:0]  cfg_spacing,
    input  logic [HDR_WIDTH-1:0]  cfg_bad_hdr,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  injected_count,
    output logic [CNT_WIDTH-1:0]  passed_count
);

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] start_count_q;
    logic [CNT_WIDTH-1:0] inject_count_q;
    logic [CNT_WIDTH-1:0] spacing_q;
    logic [HDR_WIDTH-1:0] bad_hdr_q;
    logic [CNT_WIDTH-1:0] step_cnt;

    logic [CNT_WIDTH-1:0] start_count_d;
    logic [CNT_WIDTH-1:0] inject_count_d;
    logic [CNT_WIDTH-1:0] spacing_d;
    logic [HDR_WIDTH-1:0] bad_hdr_d;
    logic [CNT_WIDTH-1:0] step_d;
    logic [CNT_WIDTH-1:0] injected_d;
    logic [CNT_WIDTH-1:0] passed_d;
    logic                 busy_d;
    logic                 done_d;
    logic                 corrupt_c;
    logic                 hdr_valid_c;

    // Next-state, counter and corruption decode.
    always_comb begin
        state_next     = state;
        start_count_d  = start_count_q;
        inject_count_d = inject_count_q;
        spacing_d      = spacing_q;
        bad_hdr_d      = bad_hdr_q;
        step_d         = step_cnt;
        injected_d     = injected_count;
        passed_d       = passed_count;
        corrupt_c      = 1'b0;
        hdr_valid_c    = hdr_is_valid(in_hdr);

        if ((state != ST_IDLE) && !cfg_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && cfg_enable) begin
                        start_count_d  = cfg_start_count;
                        inject_count_d = cfg_inject_count;
                        spacing_d      = cfg_spacing;
                        bad_hdr_d      = cfg_bad_hdr;
                        step_d         = '0;
                        injected_d     = '0;
                        passed_d       = '0;
                        state_next     = (cfg_inject_count == '0) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (start_count_q == '0) begin
                        state_next = ST_INJECT;
                    end else if (hdr_valid_c) begin
                        step_d   = step_cnt + CNT_WIDTH'(1);
                        passed_d = (passed_count == '1) ? passed_count
                                                        : passed_count + CNT_WIDTH'(1);
                        if (step_d == start_count_q) begin
                            state_next = ST_INJECT;
                        end
                    end
                end
                ST_INJECT: begin
                    if (hdr_valid_c) begin
                        corrupt_c  = 1'b1;
                        injected_d = injected_count + CNT_WIDTH'(1);
                        step_d     = '0;
                        if (injected_d == inject_count_q) begin
                            state_next = ST_DONE;
                        end else if (spacing_q != '0) begin
                            state_next = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (hdr_valid_c) begin
                        step_d   = step_cnt + CNT_WIDTH'(1);
                        passed_d = (passed_count == '1) ? passed_count
                                                        : passed_count + CNT_WIDTH'(1);
                        if (step_d == spacing_q) begin
                            state_next = ST_INJECT;
                        end
                    end
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_next == ST_WAIT) || (state_next == ST_INJECT) ||
                 (state_next == ST_GAP);
        done_d = (state_next == ST_DONE);
    end

    // State register.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath, latched configuration and status registers.
    always_ff @(posedge rx_clk or posedge rx_rst) begin
        if (rx_rst) begin
            out_data       <= '0;
            out_hdr        <= '0;
            start_count_q  <= '0;
            inject_count_q <= '0;
            spacing_q      <= '0;
            bad_hdr_q      <= '0;
            step_cnt       <= '0;
            injected_count <= '0;
            passed_count   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            out_data       <= in_data;
            out_hdr        <= corrupt_c ? bad_hdr_q : in_hdr;
            start_count_q  <= start_count_d;
            inject_count_q <= inject_count_d;
            spacing_q      <= spacing_d;
            bad_hdr_q      <= bad_hdr_d;
            step_cnt       <= step_d;
            injected_count <= injected_d;
            passed_count   <= passed_d;
            busy           <= busy_d;
            done           <= done_d;
        end
    end

    // A legal sync header as the replacement would not disturb block lock.
    bad_hdr_legal: assert property (@(posedge rx_clk) disable iff (rx_rst)
        ((state == ST_IDLE) && start && cfg_enable) |->
        ((cfg_bad_hdr == HDR_BAD00) || (cfg_bad_hdr == HDR_BAD11)));

endmodule

// File: tb/tb_serdes_hdr_err_inject.sv
// Randomized bench for serdes_hdr_err_inject against a counting/modulo
// reference model of which valid headers get corrupted.
module tb_serdes_hdr_err_inject;

    logic        rx_clk;
    logic        rx_rst;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic        cfg_enable;
    logic [15:0] cfg_start_count;
    logic [15:0] cfg_inject_count;
    logic [15:0] cfg_spacing;
    logic [1:0]  cfg_bad_hdr;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] injected_count;
    logic [15:0] passed_count;

    int total = 0;
    int bad   = 0;

    // Reference model state: a run corrupts valid header number j (counted from
    // the first eligible edge after start) when j > start and
    // (j - start - 1) is a multiple of (spacing + 1), until inject_count is hit.
    int         m_active, m_sc, m_ic, m_sp, m_inj, m_pass, m_edge, m_j;
    logic [1:0] m_bad;
    logic [1:0] exp_hdr;
    logic       exp_busy;
    logic       exp_done;

    serdes_hdr_err_inject #(
        .DATA_WIDTH(64),
        .HDR_WIDTH (2),
        .CNT_WIDTH (16)
    ) dut (
        .rx_clk          (rx_clk),
        .rx_rst          (rx_rst),
        .in_data         (in_data),
        .in_hdr          (in_hdr),
        .out_data        (out_data),
        .out_hdr         (out_hdr),
        .cfg_enable      (cfg_enable),
        .cfg_start_count (cfg_start_count),
        .cfg_inject_count(cfg_inject_count),
        .cfg_spacing     (cfg_spacing),
        .cfg_bad_hdr     (cfg_bad_hdr),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .injected_count  (injected_count),
        .passed_count    (passed_count)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    function automatic logic [1:0] rand_hdr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 4) return 2'b01;
        if (r < 8) return 2'b10;
        if (r == 8) return 2'b00;
        return 2'b11;
    endfunction

    task automatic model_reset();
        m_active = 0; m_inj = 0; m_pass = 0; m_edge = 0; m_j = 0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_hdr = 2'b00;
    endtask

    task automatic model_cycle(input logic [1:0] h, input logic st, input logic en);
        logic was_done;
        logic valid;
        was_done = exp_done;
        valid    = (h == 2'b01) || (h == 2'b10);
        exp_hdr  = h;
        exp_done = 1'b0;
        if (m_active == 0) begin
            if (st && en && !was_done) begin
                m_sc = int'(cfg_start_count); m_ic = int'(cfg_inject_count);
                m_sp = int'(cfg_spacing);     m_bad = cfg_bad_hdr;
                m_inj = 0; m_pass = 0; m_edge = 0; m_j = 0;
                m_active = (m_ic != 0) ? 1 : 0;
                exp_done = (m_ic == 0);
            end
        end else if (!en) begin
            m_active = 0;
        end else begin
            m_edge++;
            if (valid && !(m_sc == 0 && m_edge == 1)) begin
                m_j++;
                if (m_j > m_sc && ((m_j - m_sc - 1) % (m_sp + 1)) == 0) begin
                    exp_hdr = m_bad;
                    m_inj++;
                    if (m_inj == m_ic) begin
                        m_active = 0;
                        exp_done = 1'b1;
                    end
                end else if (m_pass != 65535) begin
                    m_pass++;
                end
            end
        end
        exp_busy = (m_active != 0);
    endtask

    task automatic step(input logic [63:0] d, input logic [1:0] h, input logic st);
        in_data = d; in_hdr = h; start = st;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        in_data = {$urandom, $urandom}; in_hdr = 2'b01;
        #1;
        total++;
        if ({out_data, out_hdr, busy, done, injected_count, passed_count} !== 100'd0) begin
            bad++;
            $display("FAIL reset_state: got data=%h hdr=%b busy=%b done=%b inj=%0d pass=%0d, want all 0",
                     out_data, out_hdr, busy, done, injected_count, passed_count);
        end
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [63:0] d; logic [1:0] h; logic st;
        cfg_enable = 1'b0;
        for (int n = 0; n < 40; n++) begin
            d  = (n < 20) ? 64'h5555555555555555 : {$urandom, $urandom};
            h  = (n < 20) ? 2'b01 : rand_hdr();
            st = 1'($urandom_range(0, 1));
            step(d, h, st);
            model_cycle(h, st, cfg_enable);
            total++;
            if (out_data !== d || out_hdr !== exp_hdr) begin
                bad++;
                $display("FAIL passthrough path n=%0d: got %h/%b, want %h/%b", n, out_data, out_hdr, d, exp_hdr);
            end
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || injected_count !== 16'd0) begin
                bad++;
                $display("FAIL passthrough ctl n=%0d: got busy=%b done=%b inj=%0d, want 0/0/0", n, busy, done, injected_count);
            end
        end
    endtask

    task automatic test_run(input string tag, input int sc, input int ic, input int sp, input logic [1:0] bh);
        logic [63:0] d; logic [1:0] h; logic st;
        int dones = 0;
        int tail  = -1;
        cfg_enable = 1'b1;
        cfg_start_count = 16'(sc); cfg_inject_count = 16'(ic);
        cfg_spacing = 16'(sp); cfg_bad_hdr = bh;
        for (int n = 0; n < 1500 && tail != 0; n++) begin
            d = {$urandom, $urandom}; h = rand_hdr(); st = (n == 0);
            step(d, h, st);
            model_cycle(h, st, cfg_enable);
            total++;
            if (out_data !== d || out_hdr !== exp_hdr) begin
                bad++;
                $display("FAIL %s path n=%0d: got %h/%b, want %h/%b", tag, n, out_data, out_hdr, d, exp_hdr);
            end
            total++;
            if (busy !== exp_busy || done !== exp_done) begin
                bad++;
                $display("FAIL %s ctl n=%0d: got busy=%b done=%b, want busy=%b done=%b", tag, n, busy, done, exp_busy, exp_done);
            end
            total++;
            if (injected_count !== 16'(m_inj) || passed_count !== 16'(m_pass)) begin
                bad++;
                $display("FAIL %s counts n=%0d: got inj=%0d pass=%0d, want inj=%0d pass=%0d", tag, n, injected_count, passed_count, m_inj, m_pass);
            end
            if (done === 1'b1) dones++;
            if (tail > 0) tail--;
            if (exp_done && tail < 0) tail = 4;
        end
        total++;
        if (dones != 1 || injected_count !== 16'(ic)) begin
            bad++;
            $display("FAIL %s final: got dones=%0d inj=%0d, want dones=1 inj=%0d", tag, dones, injected_count, ic);
        end
    endtask

    task automatic test_long_run();
        test_run("long_run", 200, 16, 2, 2'b00);
    endtask

    task automatic test_short_run();
        test_run("short_run", 200, 15, 2, 2'b00);
    endtask

    task automatic test_zero_inject();
        test_run("zero_inject", 7, 0, 1, 2'b11);
        total++;
        if (passed_count !== 16'd0) begin
            bad++;
            $display("FAIL zero_inject passed: got %0d, want 0", passed_count);
        end
    endtask

    task automatic test_rand_runs();
        for (int k = 0; k < 4; k++)
            test_run("rand_run", int'($urandom_range(0, 12)), int'($urandom_range(1, 9)),
                     int'($urandom_range(0, 4)), ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [63:0] d; logic [1:0] h; logic st;
        int dones = 0;
        int tail  = -1;
        cfg_enable = 1'b1;
        cfg_start_count = 16'd5; cfg_inject_count = 16'd6;
        cfg_spacing = 16'd0; cfg_bad_hdr = 2'b11;
        for (int n = 0; n < 300 && tail != 0; n++) begin
            d = {$urandom, $urandom}; h = rand_hdr();
            if (exp_busy) st = 1'($urandom_range(0, 1));
            else st = exp_done || (n == 0);
            if (n == 4) begin
                cfg_inject_count = 16'd2; cfg_start_count = 16'd0; cfg_bad_hdr = 2'b00;
            end
            step(d, h, st);
            model_cycle(h, st, cfg_enable);
            total++;
            if (out_data !== d || out_hdr !== exp_hdr) begin
                bad++;
                $display("FAIL back_to_back path n=%0d: got %h/%b, want %h/%b", n, out_data, out_hdr, d, exp_hdr);
            end
            total++;
            if (busy !== exp_busy || done !== exp_done || injected_count !== 16'(m_inj)) begin
                bad++;
                $display("FAIL back_to_back ctl n=%0d: got busy=%b done=%b inj=%0d, want %b/%b/%0d", n, busy, done, injected_count, exp_busy, exp_done, m_inj);
            end
            if (done === 1'b1) dones++;
            if (tail > 0) tail--;
            if (exp_done && tail < 0) tail = 4;
        end
        total++;
        if (dones != 1 || injected_count !== 16'd6 || busy !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back final: got dones=%0d inj=%0d busy=%b, want 1/6/0", dones, injected_count, busy);
        end
    endtask

    task automatic test_abort();
        logic [63:0] d; logic [1:0] h; logic st;
        int dones = 0;
        cfg_enable = 1'b1;
        cfg_start_count = 16'd50; cfg_inject_count = 16'd4;
        cfg_spacing = 16'd1; cfg_bad_hdr = 2'b00;
        for (int n = 0; n < 30; n++) begin
            d = {$urandom, $urandom}; h = rand_hdr(); st = (n == 0);
            cfg_enable = (n != 12);
            step(d, h, st);
            model_cycle(h, st, cfg_enable);
            total++;
            if (out_data !== d || out_hdr !== exp_hdr) begin
                bad++;
                $display("FAIL abort path n=%0d: got %h/%b, want %h/%b", n, out_data, out_hdr, d, exp_hdr);
            end
            total++;
            if (busy !== exp_busy || done !== exp_done || passed_count !== 16'(m_pass)) begin
                bad++;
                $display("FAIL abort ctl n=%0d: got busy=%b done=%b pass=%0d, want %b/%b/%0d", n, busy, done, passed_count, exp_busy, exp_done, m_pass);
            end
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || busy !== 1'b0 || passed_count === 16'd0) begin
            bad++;
            $display("FAIL abort final: got dones=%0d busy=%b pass=%0d, want 0/0/nonzero", dones, busy, passed_count);
        end
    endtask

    task automatic test_reset_mid_gap();
        logic [63:0] d; logic [1:0] h; logic st;
        int reached = 0;
        cfg_enable = 1'b1;
        cfg_start_count = 16'd3; cfg_inject_count = 16'd5;
        cfg_spacing = 16'd6; cfg_bad_hdr = 2'b11;
        for (int n = 0; n < 100 && reached == 0; n++) begin
            d = {$urandom, $urandom}; h = rand_hdr(); st = (n == 0);
            step(d, h, st);
            model_cycle(h, st, cfg_enable);
            total++;
            if (out_hdr !== exp_hdr || injected_count !== 16'(m_inj)) begin
                bad++;
                $display("FAIL gap_run n=%0d: got hdr=%b inj=%0d, want hdr=%b inj=%0d", n, out_hdr, injected_count, exp_hdr, m_inj);
            end
            if (m_inj == 1 && m_active != 0) reached = 1;
        end
        total++;
        if (reached == 0) begin
            bad++;
            $display("FAIL gap_reach: got no GAP phase within 100 cycles, want one");
        end
        #3;
        rx_rst = 1'b1;
        #1;
        total++;
        if ({out_data, out_hdr, busy, done, injected_count, passed_count} !== 100'd0) begin
            bad++;
            $display("FAIL async_reset: got data=%h hdr=%b busy=%b done=%b inj=%0d pass=%0d, want all 0",
                     out_data, out_hdr, busy, done, injected_count, passed_count);
        end
        model_reset();
        @(posedge rx_clk);
        #1;
        rx_rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            d = {$urandom, $urandom}; h = rand_hdr();
            step(d, h, 1'b0);
            model_cycle(h, 1'b0, cfg_enable);
            total++;
            if (out_data !== d || out_hdr !== h || busy !== 1'b0 || injected_count !== 16'd0) begin
                bad++;
                $display("FAIL post_reset n=%0d: got %h/%b busy=%b inj=%0d, want %h/%b busy=0 inj=0", n, out_data, out_hdr, busy, injected_count, d, h);
            end
        end
    endtask

    initial begin
        rx_rst = 1'b1; cfg_enable = 1'b0; start = 1'b0;
        in_data = '0; in_hdr = 2'b00;
        cfg_start_count = '0; cfg_inject_count = '0; cfg_spacing = '0; cfg_bad_hdr = 2'b00;
        model_reset();
        test_reset();
        test_passthrough();
        test_long_run();
        test_short_run();
        test_zero_inject();
        test_rand_runs();
        test_back_to_back();
        test_abort();
        test_reset_mid_gap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
